// File: rtl/multi_channel_mux_sequencer.sv
// multi_channel_mux_sequencer
//   Registered N-channel multiplexer with two operating modes:
//   manual (Select picks the channel) and auto scan (each channel is shown
//   for DWELL enabled cycles in turn, with a Wrap pulse on the final cycle
//   of the last channel). Entering scan costs one dead cycle; leaving it
//   does not.
//
// Parameters
//   WIDTH    data bits per channel (>=1)
//   CHANNELS number of input channels (>=2)
//   DWELL    enabled cycles spent on each channel while scanning (>=1)
//   SEL_W    derived channel-index width, max(1, clog2(CHANNELS)); fixed
//
// Ports
//   Clock        rising-edge clock
//   Reset        synchronous, active-high reset
//   In_Bus       channel k at bits [k*WIDTH +: WIDTH]
//   Select       manual-mode channel index
//   Mode         0 = manual, 1 = auto scan
//   Enable       1 = advance/update, 0 = hold
//   Out          registered selected channel data
//   Out_Channel  index of the channel currently on Out
//   Out_Valid    Out was loaded with valid data on the last edge
//   Wrap         pulse on the last dwell cycle of channel CHANNELS-1
//   Parity       even parity of Out (only with MUX_SEQ_PARITY_EN defined)
//
// Build option
//   MUX_SEQ_PARITY_EN  adds the registered Parity output.

module multi_channel_mux_sequencer #(
    parameter int unsigned  WIDTH    = 4,
    parameter int unsigned  CHANNELS = 4,
    parameter int unsigned  DWELL    = 2,
    localparam int unsigned SEL_W    = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic [WIDTH*CHANNELS-1:0] In_Bus,
    input  logic [SEL_W-1:0]          Select,
    input  logic                      Mode,
    input  logic                      Enable,
    output logic [WIDTH-1:0]          Out,
    output logic [SEL_W-1:0]          Out_Channel,
    output logic                      Out_Valid,
    output logic                      Wrap
`ifdef MUX_SEQ_PARITY_EN
    ,
    output logic                      Parity
`endif
);

    localparam int unsigned      CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [0:0]       StManual = 1'b0;
    localparam logic [0:0]       StScan   = 1'b1;
    localparam logic [SEL_W-1:0] LastPtr  = SEL_W'(CHANNELS - 1);
    localparam logic [CNT_W-1:0] LastCnt  = CNT_W'(DWELL - 1);

    logic [0:0]       state_q, state_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [SEL_W-1:0] ch_q, ch_d;
    logic             valid_q, valid_d;
    logic             wrap_q, wrap_d;
    logic             do_manual;
    logic             sel_ok;

    // Decoded mux: an index outside 0..CHANNELS-1 yields zero, never an
    // out-of-range slice.
    function automatic logic [WIDTH-1:0] pick(input logic [WIDTH*CHANNELS-1:0] bus,
                                              input logic [SEL_W-1:0]          idx);
        logic [WIDTH-1:0] v;
        v = '0;
        for (int k = 0; k < int'(CHANNELS); k++) begin
            if (idx == SEL_W'(k)) v = bus[k*WIDTH +: WIDTH];
        end
        return v;
    endfunction

    assign sel_ok = (32'(Select) < CHANNELS);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        out_d     = out_q;
        ch_d      = ch_q;
        valid_d   = 1'b0;
        wrap_d    = 1'b0;
        do_manual = 1'b0;

        if (state_q == StScan) begin
            if (Mode) begin
                if (Enable) begin
                    out_d   = pick(In_Bus, ptr_q);
                    ch_d    = ptr_q;
                    valid_d = 1'b1;
                    if (cnt_q == LastCnt) begin
                        cnt_d  = '0;
                        ptr_d  = (ptr_q == LastPtr) ? '0 : ptr_q + 1'b1;
                        wrap_d = (ptr_q == LastPtr);
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end else begin
                // Leaving scan serves the manual request in the same cycle.
                state_d   = StManual;
                ptr_d     = '0;
                cnt_d     = '0;
                do_manual = 1'b1;
            end
        end else begin
            if (Mode) begin
                // Dead cycle on scan entry, independent of Enable.
                state_d = StScan;
                ptr_d   = '0;
                cnt_d   = '0;
            end else begin
                do_manual = 1'b1;
            end
        end

        if (do_manual && Enable) begin
            if (sel_ok) begin
                out_d   = pick(In_Bus, Select);
                ch_d    = Select;
                valid_d = 1'b1;
            end else begin
                out_d = '0;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= StManual;
            ptr_q   <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            ch_q    <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            ch_q    <= ch_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
        end
    end

    assign Out         = out_q;
    assign Out_Channel = ch_q;
    assign Out_Valid   = valid_q;
    assign Wrap        = wrap_q;

`ifdef MUX_SEQ_PARITY_EN
    logic parity_q, parity_d;

    // Tracks Out exactly, so it holds whenever Out holds.
    assign parity_d = ^out_d;

    always_ff @(posedge Clock) begin
        if (Reset) parity_q <= 1'b0;
        else       parity_q <= parity_d;
    end

    assign Parity = parity_q;
`endif

endmodule

// File: tb/tb_multi_channel_mux_sequencer.sv
// Bench for multi_channel_mux_sequencer: a default instance (4 channels,
// dwell 2) and a 3-channel, dwell-1 instance share the control inputs and
// are compared every cycle with a position-counter reference model.

module tb_multi_channel_mux_sequencer;

    logic        clk;
    logic        rst;
    logic        mode;
    logic        en;
    logic [1:0]  sel;
    logic [15:0] bus_a;
    logic [11:0] bus_b;

    logic [3:0]  out_a, out_b;
    logic [1:0]  ch_a, ch_b;
    logic        val_a, val_b;
    logic        wrap_a, wrap_b;
`ifdef MUX_SEQ_PARITY_EN
    logic        par_a, par_b;
`endif

    int total = 0;
    int bad   = 0;

    // Reference state: scan position runs over 0 .. CHANNELS*DWELL-1.
    int nch[2] = '{4, 3};
    int ndw[2] = '{2, 1};
    int mscan[2];
    int mpos[2];
    int mout[2];
    int mch[2];
    int mval[2];
    int mwrap[2];

    multi_channel_mux_sequencer #(.WIDTH(4), .CHANNELS(4), .DWELL(2)) u_dut_a (
        .Clock       (clk),
        .Reset       (rst),
        .In_Bus      (bus_a),
        .Select      (sel),
        .Mode        (mode),
        .Enable      (en),
        .Out         (out_a),
        .Out_Channel (ch_a),
        .Out_Valid   (val_a),
        .Wrap        (wrap_a)
`ifdef MUX_SEQ_PARITY_EN
        ,
        .Parity      (par_a)
`endif
    );

    multi_channel_mux_sequencer #(.WIDTH(4), .CHANNELS(3), .DWELL(1)) u_dut_b (
        .Clock       (clk),
        .Reset       (rst),
        .In_Bus      (bus_b),
        .Select      (sel),
        .Mode        (mode),
        .Enable      (en),
        .Out         (out_b),
        .Out_Channel (ch_b),
        .Out_Valid   (val_b),
        .Wrap        (wrap_b)
`ifdef MUX_SEQ_PARITY_EN
        ,
        .Parity      (par_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input int i, input logic r, input logic m, input logic e,
                              input logic [1:0] s);
        int          span;
        int          c;
        logic [31:0] bus;
        bus  = (i == 0) ? 32'(bus_a) : 32'(bus_b);
        span = nch[i] * ndw[i];
        if (r) begin
            mscan[i] = 0; mpos[i] = 0; mout[i] = 0; mch[i] = 0; mval[i] = 0; mwrap[i] = 0;
        end else if (m && mscan[i] == 0) begin
            mscan[i] = 1; mpos[i] = 0; mval[i] = 0; mwrap[i] = 0;
        end else if (m) begin
            mval[i] = 0; mwrap[i] = 0;
            if (e) begin
                c        = mpos[i] / ndw[i];
                mout[i]  = int'((bus >> (c * 4)) & 32'hF);
                mch[i]   = c;
                mval[i]  = 1;
                mwrap[i] = (mpos[i] == span - 1) ? 1 : 0;
                mpos[i]  = (mpos[i] + 1) % span;
            end
        end else begin
            mscan[i] = 0; mpos[i] = 0; mval[i] = 0; mwrap[i] = 0;
            if (e) begin
                if (int'(s) < nch[i]) begin
                    mout[i] = int'((bus >> (int'(s) * 4)) & 32'hF);
                    mch[i]  = int'(s);
                    mval[i] = 1;
                end else begin
                    mout[i] = 0;
                end
            end
        end
    endtask

    task automatic check_all();
        chk("a_out",   32'(out_a),  32'(mout[0]));
        chk("a_ch",    32'(ch_a),   32'(mch[0]));
        chk("a_valid", 32'(val_a),  32'(mval[0]));
        chk("a_wrap",  32'(wrap_a), 32'(mwrap[0]));
        chk("b_out",   32'(out_b),  32'(mout[1]));
        chk("b_ch",    32'(ch_b),   32'(mch[1]));
        chk("b_valid", 32'(val_b),  32'(mval[1]));
        chk("b_wrap",  32'(wrap_b), 32'(mwrap[1]));
`ifdef MUX_SEQ_PARITY_EN
        chk("a_par",   32'(par_a),  32'(^mout[0]));
        chk("b_par",   32'(par_b),  32'(^mout[1]));
`endif
    endtask

    task automatic step(input logic r, input logic m, input logic e, input logic [1:0] s);
        rst  = r;
        mode = m;
        en   = e;
        sel  = s;
        @(posedge clk);
        model_step(0, r, m, e, s);
        model_step(1, r, m, e, s);
        #1;
        check_all();
    endtask

    initial begin
        rst   = 1'b1;
        mode  = 1'b0;
        en    = 1'b0;
        sel   = 2'd0;
        bus_a = 16'h0FA5;
        bus_b = 12'hA53;

        // Reset, then a manual pick of channel 1.
        step(1'b1, 1'b0, 1'b0, 2'd0);
        step(1'b1, 1'b0, 1'b0, 2'd0);
        chk("rst_out",   32'(out_a), 32'h0);
        chk("rst_valid", 32'(val_a), 32'h0);
        step(1'b0, 1'b0, 1'b1, 2'd1);
        chk("man1_out", 32'(out_a), 32'hA);
        chk("man1_ch",  32'(ch_a),  32'h1);

        // Manual sequence 0,2,3; Select 3 is out of range for the 3-channel copy.
        step(1'b0, 1'b0, 1'b1, 2'd0);
        step(1'b0, 1'b0, 1'b1, 2'd2);
        chk("man2_out", 32'(out_a), 32'hF);
        step(1'b0, 1'b0, 1'b1, 2'd3);
        chk("b_badsel_out",   32'(out_b), 32'h0);
        chk("b_badsel_valid", 32'(val_b), 32'h0);
        step(1'b0, 1'b0, 1'b0, 2'd3);
        chk("hold_valid", 32'(val_a), 32'h0);

        // Scan entry: dead cycle, then walk the channels.
        step(1'b0, 1'b1, 1'b1, 2'd1);
        chk("dead_valid", 32'(val_a), 32'h0);
        for (int k = 1; k <= 13; k++) begin
            step(1'b0, 1'b1, 1'b1, 2'(k));
            chk("scan_ch", 32'(ch_a), 32'(((k - 1) / 2) % 4));
            chk("scan_wrap", 32'(wrap_a), (k == 8) ? 32'h1 : 32'h0);
        end

        // Pause mid-dwell on channel 2, then resume.
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b1, 1'b0, 2'd0);
            chk("pause_out", 32'(out_a), 32'hF);
        end
        step(1'b0, 1'b1, 1'b1, 2'd0);
        chk("resume_ch2", 32'(ch_a), 32'h2);
        step(1'b0, 1'b1, 1'b1, 2'd0);
        chk("resume_ch3", 32'(ch_a), 32'h3);

        // Reset mid-scan with Mode held high.
        step(1'b1, 1'b1, 1'b1, 2'd0);
        step(1'b0, 1'b1, 1'b1, 2'd0);
        chk("rescan_dead", 32'(val_a), 32'h0);
        step(1'b0, 1'b1, 1'b1, 2'd0);
        chk("rescan_ch0", 32'(ch_a), 32'h0);

        // Leaving scan serves Select immediately; ch3=7 gives odd data.
        bus_a = 16'h7FA5;
        step(1'b0, 1'b0, 1'b1, 2'd3);
        chk("exit_out", 32'(out_a), 32'h7);

        // Randomized phase.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 2) == 0) bus_a = 16'($urandom);
            if ($urandom_range(0, 2) == 0) bus_b = 12'($urandom);
            step(($urandom_range(0, 40) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 9) < 7) ? mode : ~mode,
                 ($urandom_range(0, 4) != 0) ? 1'b1 : 1'b0,
                 2'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
